// File: rtl/mouse_bus_interface.sv
// Event FIFO for mouse transceiver updates, exposed as a six-register window on the
// 8-bit processor bus. A level interrupt flags new events when enabled.
module mouse_bus_interface #(
  parameter logic [7:0] BASE_ADDR    = 8'hA0,
  parameter int         DEPTH        = 4,
  parameter logic       IRQ_EN_RESET = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] MOUSE_STATUS,
  input  logic [7:0] MOUSE_X,
  input  logic [7:0] MOUSE_Y,
  input  logic [7:0] MOUSE_SCROLL,
  input  logic       MOUSE_UPDATE,
  input  logic [7:0] BUS_ADDR,
  input  logic [7:0] BUS_DATA_IN,
  input  logic       BUS_WE,
  input  logic       BUS_RE,
  output logic [7:0] BUS_DATA_OUT,
  output logic       BUS_DATA_OE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [27:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          overflow_reg, overflow_next;
  logic          irq_en_reg, irq_en_next;
  logic          raise_reg, raise_next;
  logic [7:0]    data_out_reg;
  logic          oe_reg;

  logic [5:0]    sel;
  logic          in_window, empty, full, do_push, do_pop, ctrl_wr;
  logic [27:0]   head;
  logic [7:0]    rd_data;
  logic [5:0]    data_in_unused;

  // One-hot decode of the register window, one comparator per register.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_decode
      assign sel[gi] = (BUS_ADDR == BASE_ADDR + 8'(gi));
    end
  endgenerate

  assign in_window      = |sel;
  assign data_in_unused = BUS_DATA_IN[7:2];
  assign empty          = (count_reg == '0);
  assign full           = (count_reg == CW'(DEPTH));
  assign do_pop         = BUS_WE && sel[4] && !empty;
  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
  assign do_push        = MOUSE_UPDATE && (!full || do_pop);
  assign ctrl_wr        = BUS_WE && sel[5];
  assign head           = empty ? 28'd0 : fifo_mem[rd_ptr_reg];

  always_ff @(posedge CLK) begin
    if (RESET && do_push)
      fifo_mem[wr_ptr_reg] <= {MOUSE_STATUS, MOUSE_X, MOUSE_Y, MOUSE_SCROLL};
  end

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop)
      count_next = count_reg + CW'(1);
    else if (do_pop && !do_push)
      count_next = count_reg - CW'(1);
  end

  always_comb begin
    overflow_next = overflow_reg;
    if (MOUSE_UPDATE && full && !do_pop)
      overflow_next = 1'b1;
    else if (ctrl_wr && BUS_DATA_IN[1])
      overflow_next = 1'b0;
  end

  always_comb begin
    irq_en_next = ctrl_wr ? BUS_DATA_IN[0] : irq_en_reg;
    // A push outranks a same-cycle acknowledge; enabling with events pending re-raises.
    raise_next  = irq_en_next &&
                  (do_push ||
                   (ctrl_wr && !irq_en_reg && BUS_DATA_IN[0] && !empty) ||
                   (raise_reg && !BUS_INTERRUPT_ACK));
  end

  always_comb begin
    rd_data = 8'd0;
    if (sel[0]) rd_data = {4'b0, head[27:24]};
    if (sel[1]) rd_data = head[23:16];
    if (sel[2]) rd_data = head[15:8];
    if (sel[3]) rd_data = head[7:0];
    if (sel[4]) rd_data = {overflow_reg, irq_en_reg, 1'b0, 5'(count_reg)};
    if (sel[5]) rd_data = {7'b0, irq_en_reg};
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      irq_en_reg   <= IRQ_EN_RESET;
      raise_reg    <= 1'b0;
      data_out_reg <= 8'd0;
      oe_reg       <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      irq_en_reg   <= irq_en_next;
      raise_reg    <= raise_next;
      oe_reg       <= BUS_RE && in_window;
      data_out_reg <= (BUS_RE && in_window) ? rd_data : 8'd0;
    end
  end

  assign BUS_DATA_OUT        = data_out_reg;
  assign BUS_DATA_OE         = oe_reg;
  assign BUS_INTERRUPT_RAISE = raise_reg;

endmodule

// File: tb/tb_mouse_bus_interface.sv
// Directed bench for mouse_bus_interface: register reads, FIFO order/overflow,
// simultaneous push/pop and interrupt behaviour with hand-computed expectations.
module tb_mouse_bus_interface;
  localparam logic [7:0] B = 8'hA0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] m_status;
  logic [7:0] m_x, m_y, m_scroll;
  logic       m_update;
  logic [7:0] bus_addr, bus_din, bus_dout;
  logic       bus_we, bus_re, bus_oe, irq_raise, irq_ack;

  int checks = 0;
  int failures = 0;

  logic [27:0] ev  [5] = '{28'h2_11_21_31, 28'h3_12_22_32, 28'h4_13_23_33,
                           28'h5_14_24_34, 28'h6_15_25_35};
  logic [27:0] fv  [5] = '{28'h8_41_51_61, 28'h9_42_52_62, 28'hA_43_53_63,
                           28'hB_44_54_64, 28'hC_45_55_65};

  mouse_bus_interface #(.BASE_ADDR(B), .DEPTH(4), .IRQ_EN_RESET(1'b0)) dut (
    .CLK(clk), .RESET(rst_n),
    .MOUSE_STATUS(m_status), .MOUSE_X(m_x), .MOUSE_Y(m_y), .MOUSE_SCROLL(m_scroll),
    .MOUSE_UPDATE(m_update),
    .BUS_ADDR(bus_addr), .BUS_DATA_IN(bus_din), .BUS_WE(bus_we), .BUS_RE(bus_re),
    .BUS_DATA_OUT(bus_dout), .BUS_DATA_OE(bus_oe),
    .BUS_INTERRUPT_RAISE(irq_raise), .BUS_INTERRUPT_ACK(irq_ack)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else
      $display("ok   %s: %0h", tag, got);
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [7:0] d, output logic oe);
    @(negedge clk); bus_addr = a; bus_re = 1'b1;
    @(negedge clk); bus_re = 1'b0;
    d = bus_dout; oe = bus_oe;
  endtask

  task automatic rd_expect(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d; logic oe;
    bus_rd(a, d, oe);
    check_eq(tag, {23'd0, oe, d}, {23'd0, 1'b1, exp});
  endtask

  task automatic rd_none(input string tag, input logic [7:0] a);
    logic [7:0] d; logic oe;
    bus_rd(a, d, oe);
    check_eq(tag, {23'd0, oe, d}, 32'd0);
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); bus_addr = a; bus_din = d; bus_we = 1'b1;
    @(negedge clk); bus_we = 1'b0;
  endtask

  task automatic set_event(input logic [27:0] e);
    {m_status, m_x, m_y, m_scroll} = e;
  endtask

  task automatic push(input logic [27:0] e);
    @(negedge clk); set_event(e); m_update = 1'b1;
    @(negedge clk); m_update = 1'b0;
  endtask

  task automatic head_expect(input string tag, input logic [27:0] e);
    rd_expect({tag, "_st"}, B + 8'd0, {4'b0, e[27:24]});
    rd_expect({tag, "_x"},  B + 8'd1, e[23:16]);
    rd_expect({tag, "_y"},  B + 8'd2, e[15:8]);
    rd_expect({tag, "_sc"}, B + 8'd3, e[7:0]);
  endtask

  initial begin
    rst_n = 1'b0; m_update = 1'b0; m_status = '0; m_x = '0; m_y = '0; m_scroll = '0;
    bus_addr = B + 8'd4; bus_din = '0; bus_we = 1'b0; bus_re = 1'b1; irq_ack = 1'b0;
    // Reset with a read in flight: nothing must come back.
    repeat (2) @(negedge clk);
    check_eq("rst_oe", {31'd0, bus_oe}, 32'd0);
    check_eq("rst_dout", {24'd0, bus_dout}, 32'd0);
    check_eq("rst_raise", {31'd0, irq_raise}, 32'd0);
    bus_re = 1'b0; rst_n = 1'b1;

    rd_expect("stat_after_rst", B + 8'd4, 8'h00);
    @(negedge clk);
    check_eq("oe_one_cycle", {31'd0, bus_oe}, 32'd0);
    check_eq("raise_idle", {31'd0, irq_raise}, 32'd0);

    // First event with interrupts enabled.
    bus_wr(B + 8'd5, 8'h01);
    push({4'h1, 8'd80, 8'd60, 8'd127});
    check_eq("raise_on_push", {31'd0, irq_raise}, 32'd1);
    head_expect("ev0", 28'h1_50_3C_7F);
    rd_expect("stat_one", B + 8'd4, 8'h41);
    rd_expect("ctrl_rd", B + 8'd5, 8'h01);
    bus_wr(B + 8'd4, 8'h00);
    rd_expect("stat_drained", B + 8'd4, 8'h40);

    // Overflow: five pushes into four slots.
    for (int i = 0; i < 5; i++) push(ev[i]);
    rd_expect("stat_ovf", B + 8'd4, 8'hC4);
    for (int i = 0; i < 4; i++) begin
      head_expect($sformatf("ovf_pop%0d", i), ev[i]);
      bus_wr(B + 8'd4, 8'hFF);
    end
    rd_expect("stat_ovf_empty", B + 8'd4, 8'hC0);
    rd_expect("head_empty_x", B + 8'd1, 8'h00);
    bus_wr(B + 8'd5, 8'h03);
    rd_expect("stat_ovf_clr", B + 8'd4, 8'h40);
    rd_expect("ctrl_after_clr", B + 8'd5, 8'h01);

    // Full FIFO: push and pop in the same cycle.
    for (int i = 0; i < 4; i++) push(fv[i]);
    @(negedge clk);
    set_event(fv[4]); m_update = 1'b1;
    bus_addr = B + 8'd4; bus_we = 1'b1;
    @(negedge clk); m_update = 1'b0; bus_we = 1'b0;
    rd_expect("stat_full_pp", B + 8'd4, 8'h44);
    for (int i = 1; i < 5; i++) begin
      head_expect($sformatf("full_pop%0d", i), fv[i]);
      bus_wr(B + 8'd4, 8'h00);
    end
    rd_expect("stat_full_drained", B + 8'd4, 8'h40);

    // Pop while empty, then a normal push/read.
    bus_wr(B + 8'd4, 8'h00);
    rd_expect("stat_empty_pop", B + 8'd4, 8'h40);
    rd_expect("head_empty_st", B + 8'd0, 8'h00);
    push(28'h5_11_22_33);
    head_expect("after_empty_pop", 28'h5_11_22_33);
    rd_expect("stat_one_again", B + 8'd4, 8'h41);

    // Read and pop of the status register together returns pre-pop count.
    @(negedge clk); bus_addr = B + 8'd4; bus_re = 1'b1; bus_we = 1'b1;
    @(negedge clk); bus_re = 1'b0; bus_we = 1'b0;
    check_eq("rd_pop_same", {23'd0, bus_oe, bus_dout}, {23'd0, 1'b1, 8'h41});
    rd_expect("stat_after_rdpop", B + 8'd4, 8'h40);

    // Interrupt: ACK with a push keeps RAISE; a lone ACK drops it.
    check_eq("raise_still", {31'd0, irq_raise}, 32'd1);
    @(negedge clk); set_event(28'h7_01_02_03); m_update = 1'b1; irq_ack = 1'b1;
    @(negedge clk); m_update = 1'b0; irq_ack = 1'b0;
    check_eq("ack_vs_push", {31'd0, irq_raise}, 32'd1);
    @(negedge clk); irq_ack = 1'b1;
    @(negedge clk); irq_ack = 1'b0;
    check_eq("ack_clears", {31'd0, irq_raise}, 32'd0);
    @(negedge clk);
    check_eq("no_rearm_pending", {31'd0, irq_raise}, 32'd0);
    bus_wr(B + 8'd5, 8'h00);
    check_eq("raise_en_off", {31'd0, irq_raise}, 32'd0);
    bus_wr(B + 8'd5, 8'h01);
    check_eq("raise_en_pending", {31'd0, irq_raise}, 32'd1);
    bus_wr(B + 8'd5, 8'h00);
    check_eq("raise_en_clear", {31'd0, irq_raise}, 32'd0);
    push(28'h3_0A_0B_0C);
    check_eq("push_irq_off", {31'd0, irq_raise}, 32'd0);
    rd_expect("stat_two", B + 8'd4, 8'h02);

    // Outside the window: no response.
    rd_none("addr_base6", B + 8'd6);
    rd_none("addr_below", B - 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
